// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display arbiter.
//   - Digit codes understood by the seven-segment scan driver
//   - Whole-display words for the idle and blanked displays
//   - Arbiter FSM state encoding
//   - Fixed-priority select helper (index 0 = highest priority)
// -----------------------------------------------------------------------------
package seg_pkg;

    // Digit codes: 0-9 are numeric, the rest are glyphs.
    localparam logic [3:0] SEG_A     = 4'hA;
    localparam logic [3:0] SEG_S     = 4'hB;
    localparam logic [3:0] SEG_C     = 4'hC;
    localparam logic [3:0] SEG_DASH  = 4'hD;
    localparam logic [3:0] SEG_BLANK = 4'hE;

    localparam logic [15:0] IDLE_WORD  = {4{SEG_DASH}};
    localparam logic [15:0] BLANK_WORD = {4{SEG_BLANK}};

    // Widest request vector the priority helper accepts.
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        LINGER = 2'd2
    } state_t;

    // Returns the lowest set index of r, or -1 when no bit is set.
    function automatic int prio_idx(input logic [MAX_REQ-1:0] r);
        int idx;
        idx = -1;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (r[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-clk tick every TICK_DIV clks.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clr    in  synchronous clear; restarts the count at 0
//   tick   out high for one clk while the count sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit seven-segment display among NUM_REQ requesters.
// The lowest-index requester wins; an owner keeps the display for at least
// HOLD_MS ticks, and may ask for its digits to blink with BLINK_MS-tick
// half-periods.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        in   level request per requester
//   req_nums   in   requester i digits at [16*i +: 16], digit3 in [15:12]
//   req_blink  in   requester i wants its digits blinked
//   grant      out  one-hot current owner, 0 when idle (registered)
//   nums       out  word to the scan driver (registered)
//   busy       out  an owner holds the display (registered)
// There is no handshake: every output is a registered level that reflects
// the inputs sampled on the previous rising edge.
// -----------------------------------------------------------------------------
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int TICK_DIV = 100000,
    parameter int HOLD_MS  = 500,
    parameter int BLINK_MS = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_nums,
    input  logic [NUM_REQ-1:0]     req_blink,
    output logic [NUM_REQ-1:0]     grant,
    output logic [15:0]            nums,
    output logic                   busy
);

    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_MS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt, top_req;
    logic [15:0]          nums_nxt, sel_nums;
    logic                 sel_blink;
    logic [HW-1:0]        hold_cnt;
    logic [BW-1:0]        blink_cnt, blink_cnt_nxt;
    logic                 phase, phase_nxt;   // 1 = hidden half of blink
    logic                 tick, grant_chg, hold_done, owner_req;
    int                   top_idx;

    assign hold_done = (hold_cnt == HOLD_MAX);
    assign owner_req = |(req & grant);
    assign grant_chg = (grant_nxt != grant);

    // Any grant change restarts the tick phase so the hold is measured from
    // the grant edge.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_chg),
        .tick  (tick)
    );

    // Highest-priority pending request as a one-hot vector.
    always_comb begin
        top_req = '0;
        top_idx = prio_idx(MAX_REQ'(req));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == top_idx) top_req[i] = 1'b1;
        end
    end

    // Ownership decisions.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (|req) begin
                    grant_nxt = top_req;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (!owner_req) begin
                    if (!hold_done) begin
                        state_nxt = LINGER;
                    end else if (|req) begin
                        grant_nxt = top_req;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (hold_done && (top_req != grant)) begin
                    // Owner still requesting: only a higher-priority index
                    // can differ from the owner in top_req.
                    grant_nxt = top_req;
                end
            end
            LINGER: begin
                if (hold_done) begin
                    if (|req) begin
                        grant_nxt = top_req;
                        state_nxt = SHOW;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (owner_req) begin
                    state_nxt = SHOW;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Blink phase and displayed word. The word uses the next phase so the
    // blanking lands on the same edge the phase flips.
    always_comb begin
        phase_nxt     = phase;
        blink_cnt_nxt = blink_cnt;
        if (grant_chg) begin
            phase_nxt     = 1'b0;
            blink_cnt_nxt = '0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                phase_nxt     = ~phase;
                blink_cnt_nxt = '0;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end

        sel_nums  = '0;
        sel_blink = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_nxt[i]) begin
                sel_nums  = sel_nums | req_nums[16*i +: 16];
                sel_blink = sel_blink | req_blink[i];
            end
        end

        nums_nxt = nums;   // LINGER keeps the captured word
        case (state_nxt)
            IDLE:    nums_nxt = IDLE_WORD;
            SHOW:    nums_nxt = (sel_blink && phase_nxt) ? BLANK_WORD : sel_nums;
            default: nums_nxt = nums;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            nums      <= IDLE_WORD;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            nums      <= nums_nxt;
            busy      <= (state_nxt != IDLE);
            phase     <= phase_nxt;
            blink_cnt <= blink_cnt_nxt;
            if (grant_chg) begin
                hold_cnt <= '0;
            end else if (tick && !hold_done) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule
